dbus_master: RTL and testbench
==============================

Name: dbus_master

Overview:
- Load/store-side initiator for the data bus (DBus).
- Converts one core memory request (address, funct3 width, store data) into a single word-aligned DBus transaction with byte strobes.
- Waits for the responder's ack, then returns aligned and extended load data to the core.
- Sits between the execute/LSU stage and DBus responders such as the machine-timer block and data RAM. Detects misaligned accesses, illegal widths and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in ACCESS without dbus_ack before the access faults; must be >=1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- req  input  1  core request, sampled only in IDLE
- req_we  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_funct3  input  3  RV32 load/store funct3
- req_wr_data  input  32  store data, right-justified
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle completion pulse
- rd_data  output  32  extended load data, valid with done
- misaligned  output  1  qualifies done: address misaligned
- fault  output  1  qualifies done: illegal funct3 or bus timeout
- dbus_rd_en  output  1  bus read enable
- dbus_wr_en  output  1  bus write enable
- dbus_addr  output  30  word address (req_addr[31:2])
- dbus_wr_data  output  32  lane-aligned store data
- dbus_wr_strobe  output  4  byte enables
- dbus_rd_data  input  32  responder read data, sampled when dbus_ack=1
- dbus_ack  input  1  responder completion; may be high in the first ACCESS cycle

Behaviour:
- Reset: clk and rst_n are as listed in Ports. While rst_n=0 at a clk edge:
  - state <= IDLE; timeout counter <= 0.
  - All outputs <= 0.
  - Reset mid-transaction drops the access with no done pulse; bus enables are low from the next edge.
- All outputs are registered.
- States: IDLE, ACCESS, RESP.
- IDLE, req=1:
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
  - Illegal funct3 -> RESP with fault=1, no bus access.
  - Halfword with addr[0]=1, or word with addr[1:0]!=0 -> RESP with misaligned=1, no bus access. Misaligned takes priority over illegal for legal-width codes only.
  - Otherwise -> ACCESS. Register dbus_addr, strobes, data and the enable.
- Store lane mapping, k=req_addr[1:0]:
  - SB: strobe=4'b0001<<k; wr_data=req_wr_data[7:0] placed in lane k, other lanes 0.
  - SH: strobe=4'b0011<<k; half placed in lanes k..k+1.
  - SW: strobe=4'b1111, data as is.
  - Loads: strobe=0, dbus_wr_data=0.
- ACCESS:
  - Exactly one of dbus_rd_en/dbus_wr_en is high. Address, data and strobe stay stable until exit.
  - dbus_ack=1 -> capture dbus_rd_data, deassert enables, go to RESP.
  - Else the counter increments. When it reaches TIMEOUT_CYCLES-1 without ack: deassert enables, go to RESP with fault=1, rd_data=0.
- RESP:
  - done=1 for exactly one cycle with rd_data/misaligned/fault; then IDLE.
  - rd_data, misaligned and fault return to 0 the cycle after done.
  - Loads: select byte/half at offset k from the captured word. LB/LH sign-extend; LBU/LHU zero-extend. Stores return rd_data=0.
- Latency: req at edge N -> enable high after N. Ack seen at edge N+1 -> done high after N+1 (pulse of 1 cycle). Minimum req->done = 2 cycles. Error paths: done 1 cycle after req.
- req while busy=1 is ignored; the core must hold req until done.
- Counter resets to 0 on every ACCESS entry. Ack and timeout in the same cycle -> ack wins, no fault.

Test Plan:
- LB addr 0x1003, responder returns 0x80xxxxxx with ack same cycle:
  - dbus_addr=0x400, rd_en for 1 cycle.
  - done 2 cycles after req; rd_data=0xFFFFFF80, fault=0.
- LHU addr 0x2002, rd_data 0xBEEF1234 -> rd_data=0x0000BEEF. LH same -> 0xFFFFBEEF.
- SB addr 0x13, data 0x000000A5 -> wr_en, strobe=4'b1000, wr_data=0xA5000000, dbus_addr=0x4. SW 0x10, 0xDEADBEEF -> strobe 4'b1111.
- LW addr 0x6 and SH addr 0x5 -> no enable ever asserted; done next cycle with misaligned=1. funct3=011 -> done with fault=1.
- Ack delayed 3 cycles (TIMEOUT_CYCLES=16) -> enables held 4 cycles with stable addr/data; done once. Ack never -> enables drop after 16 cycles; done, fault=1, rd_data=0. Second req while busy is ignored.
- rst_n low during ACCESS -> enables 0 next edge, no done. A new req after reset completes normally.

Source files
------------

// File: rtl/dbus_master.sv
// dbus_master: converts one core load/store request into a single word-aligned
// DBus transaction with byte strobes, then returns aligned/extended load data.
// Misaligned addresses, illegal funct3 codes and bus timeouts complete with a
// qualified done pulse instead of (or after) a bus access.
module dbus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        misaligned,
    output logic        fault,
    output logic        dbus_rd_en,
    output logic        dbus_wr_en,
    output logic [29:0] dbus_addr,
    output logic [31:0] dbus_wr_data,
    output logic [3:0]  dbus_wr_strobe,
    input  logic [31:0] dbus_rd_data,
    input  logic        dbus_ack
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          misal_q, misal_d;
    logic          fault_q, fault_d;
    logic          rd_en_q, rd_en_d;
    logic          wr_en_q, wr_en_d;
    logic [29:0]   addr_q, addr_d;
    logic [31:0]   wd_q, wd_d;
    logic [3:0]    strb_q, strb_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;

    logic          is_half, is_word, legal, misal_req;
    logic [3:0]    req_strb;
    logic [31:0]   req_wd;
    logic [31:0]   lshift;
    logic [31:0]   load_val;

    // Decode the request width/legality and build the lane-aligned store image.
    always_comb begin
        is_half  = 1'b0;
        is_word  = 1'b0;
        legal    = 1'b0;
        req_strb = '0;
        req_wd   = '0;
        case (req_funct3)
            3'b000: legal = 1'b1;
            3'b001: begin legal = 1'b1; is_half = 1'b1; end
            3'b010: begin legal = 1'b1; is_word = 1'b1; end
            3'b100: legal = !req_we;
            3'b101: begin legal = !req_we; is_half = 1'b1; end
            default: legal = 1'b0;
        endcase
        // Alignment is judged on width alone, so it outranks the load/store legality check.
        misal_req = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
        if (req_we) begin
            case (req_funct3)
                3'b000: begin
                    req_strb = 4'b0001 << req_addr[1:0];
                    req_wd   = {24'b0, req_wr_data[7:0]} << {req_addr[1:0], 3'b000};
                end
                3'b001: begin
                    req_strb = 4'b0011 << req_addr[1:0];
                    req_wd   = {16'b0, req_wr_data[15:0]} << {req_addr[1:0], 3'b000};
                end
                3'b010: begin
                    req_strb = 4'b1111;
                    req_wd   = req_wr_data;
                end
                default: begin
                    req_strb = '0;
                    req_wd   = '0;
                end
            endcase
        end
    end

    // Select and extend the addressed byte/half from the responder's word.
    always_comb begin
        lshift = dbus_rd_data >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{lshift[7]}}, lshift[7:0]};
            3'b001:  load_val = {{16{lshift[15]}}, lshift[15:0]};
            3'b010:  load_val = lshift;
            3'b100:  load_val = {24'b0, lshift[7:0]};
            3'b101:  load_val = {16'b0, lshift[15:0]};
            default: load_val = '0;
        endcase
    end

    // Next-state logic for the IDLE -> ACCESS -> RESP sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        rd_data_d = '0;
        misal_d   = 1'b0;
        fault_d   = 1'b0;
        rd_en_d   = rd_en_q;
        wr_en_d   = wr_en_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        strb_d    = strb_q;
        we_d      = we_q;
        f3_d      = f3_q;
        off_d     = off_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (misal_req) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        misal_d = 1'b1;
                    end else if (!legal) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                        rd_en_d = !req_we;
                        wr_en_d = req_we;
                        addr_d  = req_addr[31:2];
                        wd_d    = req_wd;
                        strb_d  = req_strb;
                        we_d    = req_we;
                        f3_d    = req_funct3;
                        off_d   = req_addr[1:0];
                    end
                end
            end
            S_ACCESS: begin
                if (dbus_ack) begin
                    state_d   = S_RESP;
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b0;
                    done_d    = 1'b1;
                    rd_data_d = we_q ? '0 : load_val;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            misal_q   <= 1'b0;
            fault_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            strb_q    <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            misal_q   <= misal_d;
            fault_q   <= fault_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            strb_q    <= strb_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign rd_data        = rd_data_q;
    assign misaligned     = misal_q;
    assign fault          = fault_q;
    assign dbus_rd_en     = rd_en_q;
    assign dbus_wr_en     = wr_en_q;
    assign dbus_addr      = addr_q;
    assign dbus_wr_data   = wd_q;
    assign dbus_wr_strobe = strb_q;

endmodule

// File: tb/tb_dbus_master.sv
// Self-checking bench for dbus_master: directed cases plus randomized
// transactions compared against a behavioural model of the load/store rules.
module tb_dbus_master;

    localparam int TO = 16;
    localparam int K_OK = 0;
    localparam int K_MIS = 1;
    localparam int K_ILL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wr_data;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic        misaligned;
    logic        fault;
    logic        dbus_rd_en;
    logic        dbus_wr_en;
    logic [29:0] dbus_addr;
    logic [31:0] dbus_wr_data;
    logic [3:0]  dbus_wr_strobe;
    logic [31:0] dbus_rd_data;
    logic        dbus_ack;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    dbus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wr_data(req_wr_data),
        .busy(busy), .done(done), .rd_data(rd_data), .misaligned(misaligned),
        .fault(fault), .dbus_rd_en(dbus_rd_en), .dbus_wr_en(dbus_wr_en),
        .dbus_addr(dbus_addr), .dbus_wr_data(dbus_wr_data),
        .dbus_wr_strobe(dbus_wr_strobe), .dbus_rd_data(dbus_rd_data),
        .dbus_ack(dbus_ack)
    );

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic int classify(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = size_of(f3);
        if (sz > 1 && (int'(a[1:0]) % sz) != 0) return K_MIS;
        if (sz == 0 || (we && f3[2])) return K_ILL;
        return K_OK;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] k,
                                               input logic [31:0] word);
        int sz;
        longint v;
        longint span;
        sz = size_of(f3);
        if (sz == 4) return word;
        span = longint'(1) << (8 * sz);
        v = longint'(word >> (8 * int'(k))) % span;
        if (!f3[2] && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic store_model(input logic [2:0] f3, input logic [1:0] k, input logic [31:0] wd,
                               output logic [3:0] strb, output logic [31:0] data);
        int sz;
        sz = size_of(f3);
        strb = '0;
        data = '0;
        for (int b = 0; b < 4; b++) begin
            if (b >= int'(k) && b < int'(k) + sz) begin
                strb[b] = 1'b1;
                data[8*b +: 8] = wd[8*(b - int'(k)) +: 8];
            end
        end
    endtask

    // ---------------- one transaction with inline checks ----------------
    // delay: ack arrives in enabled cycle delay+1; negative means never.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rword, input int delay);
        int kind;
        int en_cnt;
        int exp_en;
        bit got_done;
        logic exp_fault;
        logic [31:0] exp_rd;
        logic [3:0] exp_strb;
        logic [31:0] exp_wd;
        kind = classify(we, f3, a);
        @(negedge clk);
        req = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wr_data = wd;
        dbus_ack = 1'b0;
        if (kind != K_OK) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || misaligned !== (kind == K_MIS) || fault !== (kind == K_ILL) ||
                rd_data !== 32'h0 || dbus_rd_en !== 1'b0 || dbus_wr_en !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL err_path f3=%b a=%h: done=%b mis=%b flt=%b rd=%h en=%b%b, want done=1 mis=%b flt=%b rd=0 en=00",
                         f3, a, done, misaligned, fault, rd_data, dbus_rd_en, dbus_wr_en,
                         kind == K_MIS, kind == K_ILL);
            end
            req = 1'b0;
        end else begin
            if (we) store_model(f3, a[1:0], wd, exp_strb, exp_wd);
            else begin exp_strb = '0; exp_wd = '0; end
            exp_rd    = we ? 32'h0 : load_model(f3, a[1:0], rword);
            exp_en    = (delay < 0 || delay + 1 > TO) ? TO : delay + 1;
            exp_fault = (delay < 0 || delay >= TO);
            en_cnt = 0;
            got_done = 1'b0;
            for (int i = 0; i < 40 && !got_done; i++) begin
                @(negedge clk);
                if (done === 1'b1) got_done = 1'b1;
                else begin
                    checks++;
                    if (dbus_rd_en !== !we || dbus_wr_en !== we || dbus_addr !== a[31:2] ||
                        dbus_wr_strobe !== exp_strb || dbus_wr_data !== exp_wd || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL access f3=%b a=%h cyc=%0d: rd/wr=%b%b addr=%h strb=%b wd=%h busy=%b, want %b%b %h %b %h 1",
                                 f3, a, en_cnt, dbus_rd_en, dbus_wr_en, dbus_addr, dbus_wr_strobe,
                                 dbus_wr_data, busy, !we, we, a[31:2], exp_strb, exp_wd);
                    end
                    en_cnt++;
                    dbus_ack = (delay >= 0 && en_cnt == delay + 1);
                    dbus_rd_data = dbus_ack ? rword : $urandom;
                end
            end
            dbus_ack = 1'b0;
            req = 1'b0;
            checks++;
            if (!got_done || en_cnt != exp_en) begin
                errors++;
                $display("FAIL timing f3=%b a=%h delay=%0d: done_seen=%b enabled_cycles=%0d, want 1 %0d",
                         f3, a, delay, got_done, en_cnt, exp_en);
            end
            checks++;
            if (done !== 1'b1 || rd_data !== (exp_fault ? 32'h0 : exp_rd) || fault !== exp_fault ||
                misaligned !== 1'b0 || dbus_rd_en !== 1'b0 || dbus_wr_en !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL response f3=%b a=%h: done=%b rd=%h flt=%b mis=%b en=%b%b, want 1 %h %b 0 00",
                         f3, a, done, rd_data, fault, misaligned, dbus_rd_en, dbus_wr_en,
                         exp_fault ? 32'h0 : exp_rd, exp_fault);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || rd_data !== 32'h0 || fault !== 1'b0 || misaligned !== 1'b0 ||
            busy !== 1'b0 || dbus_rd_en !== 1'b0 || dbus_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL after_done f3=%b a=%h: done=%b rd=%h flt=%b mis=%b busy=%b en=%b%b, want all 0",
                     f3, a, done, rd_data, fault, misaligned, busy, dbus_rd_en, dbus_wr_en);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = '0; req_funct3 = '0;
        req_wr_data = '0; dbus_rd_data = '0; dbus_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_data !== 32'h0 || misaligned !== 1'b0 ||
            fault !== 1'b0 || dbus_rd_en !== 1'b0 || dbus_wr_en !== 1'b0 || dbus_addr !== 30'h0 ||
            dbus_wr_data !== 32'h0 || dbus_wr_strobe !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b rd=%h en=%b%b addr=%h wd=%h strb=%b, want all 0",
                     busy, done, rd_data, dbus_rd_en, dbus_wr_en, dbus_addr, dbus_wr_data, dbus_wr_strobe);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8012_3456, 0);
        run_txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0);
        run_txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1);
        run_txn(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0);
        run_txn(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 2);
        run_txn(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0);
        run_txn(1'b1, 3'b001, 32'h0000_0005, 32'h1234_5678, 32'h0, 0);
        run_txn(1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0);
        run_txn(1'b1, 3'b001, 32'h0000_0022, 32'h0000_CAFE, 32'h0, 0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1111_2222, 3);
        run_txn(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h3333_4444, -1);
        run_txn(1'b1, 3'b010, 32'h0000_0048, 32'h5555_6666, 32'h0, TO - 1);
        run_txn(1'b0, 3'b100, 32'h0000_004D, 32'h0, 32'h00F0_0000, TO);
    endtask

    task automatic test_busy_ignore();
        int dones;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wr_data = '0;
        @(negedge clk);
        req = 1'b0; req_addr = 32'h200; req_we = 1'b1;
        @(negedge clk);
        checks++;
        if (dbus_rd_en !== 1'b1 || dbus_wr_en !== 1'b0 || dbus_addr !== 30'h40) begin
            errors++;
            $display("FAIL busy_hold: rd/wr=%b%b addr=%h, want 10 040", dbus_rd_en, dbus_wr_en, dbus_addr);
        end
        req = 1'b1; dbus_ack = 1'b1; dbus_rd_data = 32'h1234_5678;
        @(negedge clk);
        req = 1'b0; dbus_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || rd_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL busy_done: done=%b rd=%h, want 1 12345678", done, rd_data);
        end
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1 || dbus_rd_en === 1'b1 || dbus_wr_en === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL busy_ignored: extra activity cycles=%0d, want 0", dones);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80; dbus_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; req = 1'b0;
        @(negedge clk);
        checks++;
        if (dbus_rd_en !== 1'b0 || dbus_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: en=%b%b busy=%b done=%b, want 00 0 0",
                     dbus_rd_en, dbus_wr_en, busy, done);
        end
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1 || dbus_rd_en === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_done: activity cycles=%0d, want 0", seen);
        end
        run_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8000_0000, 0);
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        int          d;
        int          r;
        for (int n = 0; n < 150; n++) begin
            we = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    f3 = 3'b000;
                2, 3:    f3 = 3'b001;
                4, 5:    f3 = 3'b010;
                6, 7:    f3 = 3'b100;
                8:       f3 = 3'b101;
                9:       f3 = 3'b011;
                10:      f3 = 3'b110;
                default: f3 = 3'b111;
            endcase
            a = $urandom;
            if (we && f3 == 3'b101) a[0] = 1'b0;
            r = $urandom_range(0, 19);
            if (r < 14)      d = r % 5;
            else if (r < 16) d = TO - 1;
            else if (r < 18) d = TO;
            else             d = -1;
            run_txn(we, f3, a, $urandom, $urandom, d);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
